// File: rtl/jtag_tap_ctrl.sv
// ---------------------------------------------------------------------------
// JtagTapCtrl: IEEE 1149.1 TAP controller with instruction register,
// bypass register and optional 32-bit device ID register.
//
// Optional feature: define JTAG_IDCODE_EN to include the ID register, decode
// the IDCODE opcode and make IDCODE the reset instruction. Without it, opcode
// 0010 decodes as BYPASS and BYPASS is the reset instruction.
//
// Parameters:
//   IR_WIDTH      instruction register width (>= 2)
//   IDCODE_VALUE  device ID, bit 0 must be 1
// Ports:
//   TCK           the only clock, all state changes on its rising edge
//   TRST          synchronous active-high reset, overrides TMS
//   TMS, TDI      test mode select and serial data in
//   bsr_tdo       serial output of the external boundary scan register
//   TDO, TDO_en   serial data out and its enable (Shift-IR / Shift-DR)
//   dr_capture, dr_shift, dr_update  data-register phase strobes (Moore)
//   bsr_select    boundary scan register is the selected data register
//   mode          boundary scan register drives pins (EXTEST)
//   tlr_reset     high while in Test-Logic-Reset
//   instr         active instruction
// ---------------------------------------------------------------------------
module jtag_tap_ctrl #(
  parameter int unsigned IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                bsr_tdo,
  output logic                TDO,
  output logic                TDO_en,
  output logic                dr_capture,
  output logic                dr_shift,
  output logic                dr_update,
  output logic                bsr_select,
  output logic                mode,
  output logic                tlr_reset,
  output logic [IR_WIDTH-1:0] instr
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST  = '0;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] RST_INSTR  = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RST_INSTR  = OP_BYPASS;
`endif

  tap_state_t          state;
  tap_state_t          next_state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_reg;
  logic                sel_idcode;
  logic                dr_tdo;

  // TAP state register; reset wins over any TMS value.
  always_ff @(posedge TCK) begin
    if (TRST) state <= TLR;
    else      state <= next_state;
  end

  // Standard TMS-driven transitions plus Moore decode of the phase strobes.
  always_comb begin
    next_state = state;
    tlr_reset  = 1'b0;
    dr_capture = 1'b0;
    dr_shift   = 1'b0;
    dr_update  = 1'b0;
    TDO_en     = 1'b0;
    case (state)
      TLR:      begin next_state = TMS ? TLR    : RTI;    tlr_reset = 1'b1; end
      RTI:            next_state = TMS ? SEL_DR : RTI;
      SEL_DR:         next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   begin next_state = TMS ? EX1_DR : SH_DR;  dr_capture = 1'b1; end
      SH_DR:    begin next_state = TMS ? EX1_DR : SH_DR;  dr_shift = 1'b1; TDO_en = 1'b1; end
      EX1_DR:         next_state = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR:       next_state = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:         next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR:   begin next_state = TMS ? SEL_DR : RTI;    dr_update = 1'b1; end
      SEL_IR:         next_state = TMS ? TLR    : CAP_IR;
      CAP_IR:         next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:    begin next_state = TMS ? EX1_IR : SH_IR;  TDO_en = 1'b1; end
      EX1_IR:         next_state = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR:       next_state = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:         next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR:         next_state = TMS ? SEL_DR : RTI;
      default:        next_state = TLR;
    endcase
  end

  // IR shift stage: capture the fixed 01 pattern, then shift LSB-first.
  // Pause/exit states leave it untouched so a shift can be resumed.
  always_ff @(posedge TCK) begin
    if (TRST)                 ir_shift <= '0;
    else if (state == CAP_IR) ir_shift <= IR_CAPTURE;
    else if (state == SH_IR)  ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
  end

  // Active instruction changes only when leaving Update-IR, so an aborted
  // shift (reset mid-shift) never reaches it. TLR keeps re-forcing the
  // reset instruction every cycle.
  always_ff @(posedge TCK) begin
    if (TRST || state == TLR) instr <= RST_INSTR;
    else if (state == UPD_IR) instr <= ir_shift;
  end

  // Single-bit bypass register.
  always_ff @(posedge TCK) begin
    if (TRST)                 bypass_reg <= 1'b0;
    else if (state == CAP_DR) bypass_reg <= 1'b0;
    else if (state == SH_DR)  bypass_reg <= TDI;
  end

  assign bsr_select = (instr == OP_EXTEST) || (instr == OP_SAMPLE);
  assign mode       = (instr == OP_EXTEST);

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_reg;

  assign sel_idcode = (instr == OP_IDCODE);

  // Device ID register, only active while IDCODE is the instruction.
  always_ff @(posedge TCK) begin
    if (TRST)                               id_reg <= IDCODE_VALUE;
    else if (state == CAP_DR && sel_idcode) id_reg <= IDCODE_VALUE;
    else if (state == SH_DR && sel_idcode)  id_reg <= {TDI, id_reg[31:1]};
  end

  assign dr_tdo = bsr_select ? bsr_tdo : (sel_idcode ? id_reg[0] : bypass_reg);
`else
  logic unused_idcode;

  assign unused_idcode = ^IDCODE_VALUE;
  assign sel_idcode    = 1'b0;
  assign dr_tdo        = bsr_select ? bsr_tdo : bypass_reg;
`endif

  // Serial output mux; any unrecognised instruction falls through to bypass.
  always_comb begin
    TDO = 1'b0;
    if (state == SH_IR)      TDO = ir_shift[0];
    else if (state == SH_DR) TDO = dr_tdo;
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jtag_tap_ctrl: self-checking bench for jtag_tap_ctrl. A behavioural TAP
// model (transition tables plus register rules) runs alongside the DUT and
// provides expected values for the randomized walk; directed scenarios check
// reset, instruction loading, bypass, ID streaming and reset mid-shift.
// Honours JTAG_IDCODE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_jtag_tap_ctrl;

  localparam int          IR_W = 4;
  localparam logic [31:0] IDV  = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0]  RST_OP = 4'b0010;
`else
  localparam logic [3:0]  RST_OP = 4'b1111;
`endif

  localparam int S_TLR = 0, S_RTI = 1, S_CAPDR = 3, S_SHDR = 4, S_UPDDR = 8;
  localparam int S_CAPIR = 10, S_SHIR = 11, S_UPDIR = 15;

  // Next-state tables, index order: TLR RTI SelDR CapDR ShDR Ex1DR PauseDR
  // Ex2DR UpdDR SelIR CapIR ShIR Ex1IR PauseIR Ex2IR UpdIR
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic            TCK, TRST, TMS, TDI, bsr_tdo;
  logic            TDO, TDO_en, dr_capture, dr_shift, dr_update;
  logic            bsr_select, mode, tlr_reset;
  logic [IR_W-1:0] instr;

  int tests_run    = 0;
  int tests_failed = 0;

  int          m_st;
  logic [3:0]  m_irs;
  logic [3:0]  m_instr;
  logic        m_byp;
  logic [31:0] m_id;

  jtag_tap_ctrl #(.IR_WIDTH(IR_W), .IDCODE_VALUE(IDV)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .bsr_tdo(bsr_tdo),
    .TDO(TDO), .TDO_en(TDO_en), .dr_capture(dr_capture), .dr_shift(dr_shift),
    .dr_update(dr_update), .bsr_select(bsr_select), .mode(mode),
    .tlr_reset(tlr_reset), .instr(instr)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: run did not complete, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic is_idcode(input logic [3:0] op);
`ifdef JTAG_IDCODE_EN
    return op == 4'b0010;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_tdo();
    logic bsel;
    bsel = (m_instr == 4'b0000) || (m_instr == 4'b0001);
    if (m_st == S_SHIR) return m_irs[0];
    if (m_st == S_SHDR) begin
      if (bsel) return bsr_tdo;
      if (is_idcode(m_instr)) return m_id[0];
      return m_byp;
    end
    return 1'b0;
  endfunction

  // Advance the reference model by one rising edge.
  task automatic model_clock(input logic tms, input logic tdi, input logic trst);
    if (trst) begin
      m_st = S_TLR; m_byp = 1'b0; m_irs = 4'b0; m_instr = RST_OP;
    end else begin
      if (m_st == S_TLR)   m_instr = RST_OP;
      if (m_st == S_CAPIR) m_irs = 4'b0001;
      if (m_st == S_SHIR)  m_irs = {tdi, m_irs[3:1]};
      if (m_st == S_UPDIR) m_instr = m_irs;
      if (m_st == S_CAPDR) begin
        m_byp = 1'b0;
        if (is_idcode(m_instr)) m_id = IDV;
      end
      if (m_st == S_SHDR) begin
        m_byp = tdi;
        if (is_idcode(m_instr)) m_id = {tdi, m_id[31:1]};
      end
      m_st = tms ? nxt1[m_st] : nxt0[m_st];
    end
  endtask

  task automatic step(input logic tms, input logic tdi, input logic trst);
    TMS = tms; TDI = tdi; TRST = trst;
    @(posedge TCK);
    model_clock(tms, tdi, trst);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
  endtask

  // Apply TMS bits pat[0..len-1] with TDI low.
  task automatic walk(input logic [31:0] pat, input int len);
    for (int i = 0; i < len; i++) step(pat[i], 1'b0, 1'b0);
  endtask

  // Shortest TMS sequence from TLR to the target, searched on the tables.
  task automatic find_path(input int target, output logic [31:0] pat, output int len);
    pat = '0; len = 0;
    for (int l = 0; l <= 8; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        int s;
        logic [31:0] pv;
        pv = 32'(p);
        s = S_TLR;
        for (int k = 0; k < l; k++) s = pv[k] ? nxt1[s] : nxt0[s];
        if (s == target) begin pat = pv; len = l; return; end
      end
    end
  endtask

  // Reset, shift op into the IR, pass Update-IR and stop in RTI.
  task automatic load_ir(input logic [3:0] op);
    do_reset();
    walk(32'b00110, 5);
    for (int i = 0; i < 4; i++) step(i == 3, op[i], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    bsr_tdo = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    tests_run++;
    if ({tlr_reset, dr_capture, dr_shift, dr_update} !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 1000", {tlr_reset, dr_capture, dr_shift, dr_update});
    end
    tests_run++;
    if ({TDO, TDO_en, mode, bsr_select} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000", {TDO, TDO_en, mode, bsr_select});
    end
    tests_run++;
    if (instr !== RST_OP) begin
      tests_failed++;
      $display("[TB] FAIL reset_instr: got %b expected %b", instr, RST_OP);
    end
    step(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (tlr_reset !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold_tlr: got %b expected 1", tlr_reset);
    end
  endtask

  task automatic test_tlr_from_all_states();
    logic [31:0] pat;
    int len;
    for (int s = 0; s < 16; s++) begin
      do_reset();
      find_path(s, pat, len);
      walk(pat, len);
      tests_run++;
      if (tlr_reset !== (s == S_TLR)) begin
        tests_failed++;
        $display("[TB] FAIL tlr_before_%0d: got %b expected %b", s, tlr_reset, (s == S_TLR));
      end
      for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom), 1'b0);
      tests_run++;
      if (tlr_reset !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL tlr_from_%0d: got %b expected 1", s, tlr_reset);
      end
    end
  endtask

  task automatic test_extest_load();
    logic [3:0] exp_bits;
    exp_bits = 4'b0001;
    do_reset();
    walk(32'b0110, 4);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (TDO !== exp_bits[i]) begin
        tests_failed++;
        $display("[TB] FAIL extest_ir_tdo_%0d: got %b expected %b", i, TDO, exp_bits[i]);
      end
      step(i == 3, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    tests_run++;
    if ({mode, bsr_select} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL extest_in_updir: got %b expected 00", {mode, bsr_select});
    end
    step(1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({mode, bsr_select, instr} !== 6'b110000) begin
      tests_failed++;
      $display("[TB] FAIL extest_active: got %b expected 110000", {mode, bsr_select, instr});
    end
  endtask

  task automatic test_bypass(input logic [3:0] op);
    logic [3:0] tdi_seq;
    logic [3:0] tdo_seq;
    tdi_seq = 4'b1101;
    tdo_seq = 4'b1010;
    load_ir(op);
    tests_run++;
    if ({instr, bsr_select, mode} !== {op, 2'b00}) begin
      tests_failed++;
      $display("[TB] FAIL bypass_decode_%b: got %b expected %b", op, {instr, bsr_select, mode}, {op, 2'b00});
    end
    bsr_tdo = 1'b1;
    walk(32'b001, 3);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (TDO !== tdo_seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL bypass_tdo_%b_%0d: got %b expected %b", op, i, TDO, tdo_seq[i]);
      end
      step(1'b0, tdi_seq[i], 1'b0);
    end
  endtask

  task automatic test_sample_preload();
    load_ir(4'b0001);
    tests_run++;
    if ({bsr_select, mode} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL sample_decode: got %b expected 10", {bsr_select, mode});
    end
    walk(32'b001, 3);
    for (int i = 0; i < 6; i++) begin
      bsr_tdo = 1'($urandom);
      #1;
      tests_run++;
      if (TDO !== bsr_tdo) begin
        tests_failed++;
        $display("[TB] FAIL sample_tdo_%0d: got %b expected %b", i, TDO, bsr_tdo);
      end
      step(1'b0, 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_idcode();
`ifdef JTAG_IDCODE_EN
    do_reset();
    walk(32'b0010, 4);
    for (int i = 0; i < 32; i++) begin
      tests_run++;
      if (TDO !== IDV[i]) begin
        tests_failed++;
        $display("[TB] FAIL idcode_bit_%0d: got %b expected %b", i, TDO, IDV[i]);
      end
      step(1'b0, 1'($urandom), 1'b0);
    end
`else
    do_reset();
    walk(32'b0010, 4);
    tests_run++;
    if (TDO !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dr_bypass_0: got %b expected 0", TDO);
    end
    step(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (TDO !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_dr_bypass_1: got %b expected 1", TDO);
    end
    test_bypass(4'b0010);
`endif
  endtask

  task automatic test_pause_ir();
    logic [3:0] op;
    op = 4'b0001;
    do_reset();
    walk(32'b00110, 5);
    step(1'b0, op[0], 1'b0);
    step(1'b1, op[1], 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests_run++;
    if ({instr, bsr_select} !== {RST_OP, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL pause_ir_hold: got %b expected %b", {instr, bsr_select}, {RST_OP, 1'b0});
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, op[2], 1'b0);
    step(1'b1, op[3], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests_run++;
    if ({instr, bsr_select, mode} !== {op, 2'b10}) begin
      tests_failed++;
      $display("[TB] FAIL pause_ir_resume: got %b expected %b", {instr, bsr_select, mode}, {op, 2'b10});
    end
  endtask

  task automatic test_trst_mid_shift();
    load_ir(4'b0000);
    walk(32'b0011, 4);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    tests_run++;
    if ({tlr_reset, dr_update, TDO_en, mode} !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL trst_shift_state: got %b expected 1000", {tlr_reset, dr_update, TDO_en, mode});
    end
    tests_run++;
    if (instr !== RST_OP) begin
      tests_failed++;
      $display("[TB] FAIL trst_shift_instr: got %b expected %b", instr, RST_OP);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    tests_run++;
    if ({instr, tlr_reset} !== {RST_OP, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL trst_shift_after: got %b expected %b", {instr, tlr_reset}, {RST_OP, 1'b1});
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_str;
    logic [4:0] obs_str;
    logic       exp_bsel;
    logic       exp_mode;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bsr_tdo = 1'($urandom);
      step(1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
      exp_str = {m_st == S_TLR, m_st == S_CAPDR, m_st == S_SHDR, m_st == S_UPDDR,
                 (m_st == S_SHDR) || (m_st == S_SHIR)};
      obs_str = {tlr_reset, dr_capture, dr_shift, dr_update, TDO_en};
      exp_bsel = (m_instr == 4'b0000) || (m_instr == 4'b0001);
      exp_mode = (m_instr == 4'b0000);
      tests_run++;
      if (obs_str !== exp_str) begin
        tests_failed++;
        $display("[TB] FAIL rand_strobes_%0d: got %b expected %b", n, obs_str, exp_str);
      end
      tests_run++;
      if (TDO !== exp_tdo()) begin
        tests_failed++;
        $display("[TB] FAIL rand_tdo_%0d: got %b expected %b", n, TDO, exp_tdo());
      end
      tests_run++;
      if ({instr, bsr_select, mode} !== {m_instr, exp_bsel, exp_mode}) begin
        tests_failed++;
        $display("[TB] FAIL rand_instr_%0d: got %b expected %b", n, {instr, bsr_select, mode}, {m_instr, exp_bsel, exp_mode});
      end
    end
  endtask

  initial begin
    TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0;
    m_st = S_TLR; m_irs = '0; m_instr = RST_OP; m_byp = 1'b0; m_id = IDV;
    test_reset();
    test_tlr_from_all_states();
    test_extest_load();
    test_bypass(4'b1111);
    test_bypass(4'b1010);
    test_sample_preload();
    test_idcode();
    test_pause_ir();
    test_trst_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register width in bits.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h1000_0001, device ID; bit 0 SHALL be 1.
REQ-003 SHALL have port TCK, input, 1, the only clock; all state updates occur on the rising edge, with no negedge logic.
REQ-004 SHALL have port TRST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port TMS, input, 1, test mode select, sampled on the TCK rising edge.
REQ-006 SHALL have port TDI, input, 1, serial data in.
REQ-007 SHALL have port bsr_tdo, input, 1, serial output of the boundary scan register.
REQ-008 SHALL have port TDO, output, 1, serial data out.
REQ-009 SHALL have port TDO_en, output, 1, high while in Shift-IR or Shift-DR.
REQ-010 SHALL have ports dr_capture, dr_shift and dr_update, output, 1 each, data-register phase strobes.
REQ-011 SHALL have port bsr_select, output, 1, high when the BSR is the selected data register.
REQ-012 SHALL have port mode, output, 1, BSR drives pins from its update stage.
REQ-013 SHALL have port tlr_reset, output, 1, high while in Test-Logic-Reset.
REQ-014 SHALL have port instr, output, IR_WIDTH, current active instruction.

Function
REQ-015 SHALL implement the 16-state IEEE 1149.1 TAP FSM: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR, with the standard TMS transitions.
REQ-016 SHALL reach TLR after at most 5 consecutive TCK cycles with TMS=1, from any state.
REQ-017 SHALL drive dr_capture, dr_shift, dr_update and tlr_reset as Moore outputs, decoded from the current state only (CapDR, ShDR, UpdDR, TLR respectively), each high exactly for the cycles spent in that state.
REQ-018 SHALL load the IR shift register with {0..0,2'b01} on the edge leaving CapIR.
REQ-019 SHALL, on each edge while in ShIR, shift the IR shift register right with TDI into the MSB.
REQ-020 SHALL copy the IR shift register to instr on the edge leaving UpdIR; instr SHALL be unchanged in all other states.
REQ-021 SHALL decode the opcodes EXTEST=0000, SAMPLE_PRELOAD=0001, IDCODE=0010 and BYPASS=1111; any other code SHALL decode as BYPASS.
REQ-022 SHALL assert bsr_select when instr is EXTEST or SAMPLE_PRELOAD.
REQ-023 SHALL assert mode only when instr is EXTEST.
REQ-024 SHALL provide a 1-bit bypass register that captures 0 in CapDR and loads TDI in ShDR.
REQ-025 SHALL provide a 32-bit ID register that captures IDCODE_VALUE in CapDR and shifts right with TDI into bit 31 in ShDR, when instr is IDCODE.
REQ-026 SHALL drive TDO combinationally as follows: ShIR gives IR-shift[0]; ShDR gives bsr_tdo, ID[0] or bypass according to instr; all other states give 0.
REQ-027 SHALL hold instr, bsr_select and mode stable during all DR states; an instruction change SHALL take effect in the cycle after UpdIR.
REQ-028 SHALL NOT alter the instruction when passing through PauseIR or Ex2IR, and SHALL preserve the shift contents across pause states.

Reset
REQ-029 SHALL, on TRST=1 at a rising edge, set state=TLR, bypass=0 and IR shift register=0, and load instr with IDCODE (or BYPASS when IDCODE_EN is undefined); TRST SHALL take priority over TMS.
REQ-030 SHALL, while in TLR, force instr to the reset instruction every cycle, regardless of TRST.
REQ-031 SHALL, when reset is asserted mid-shift, abandon the shift with no update strobe, so that dr_update and instr are unaffected by the partial data.
REQ-032 SHALL have every output at its reset-state value on the first cycle after reset: tlr_reset=1, all strobes 0, TDO=0, TDO_en=0, mode=0, bsr_select=0.

Configuration
REQ-033 SHALL, with JTAG_IDCODE_EN defined, include the 32-bit ID register, decode IDCODE, and reset instr to IDCODE.
REQ-034 SHALL, without JTAG_IDCODE_EN, omit the ID register, decode opcode 0010 as BYPASS, and reset instr to BYPASS.

Verification
REQ-035 SHALL cover: from ShDR, apply 5 cycles of TMS=1, then expect state TLR and tlr_reset=1; repeat from every state.
REQ-036 SHALL cover: shift IR=0000 via SelDR, SelIR, CapIR, ShIR x4 and UpdIR, then expect mode=1 and bsr_select=1 from the next cycle; the first 4 TDO bits during ShIR SHALL be 1,0,0,0.
REQ-037 SHALL cover: with JTAG_IDCODE_EN defined, after reset go to ShDR and shift 32 cycles, then expect TDO to stream IDCODE_VALUE LSB-first.
REQ-038 SHALL cover: load BYPASS, then in ShDR drive TDI 1,0,1,1, then expect TDO 0,1,0,1 (one-cycle delay).
REQ-039 SHALL cover: load opcode 1010, then expect BYPASS behaviour with bsr_select=0 and mode=0.
REQ-040 SHALL cover: assert TRST on the 2nd ShIR cycle, then expect TLR the next cycle and instr equal to the reset instruction, with no ir update.
